// File: rtl/mcu_pkg.sv
// Shared types and constants for the program-memory server.
// State encoding, RAM depth and loader byte order.
package mcu_pkg;

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    RUN
  } state_e;

  localparam int          PROG_DEPTH  = 256;
  localparam logic [15:0] NOP_WORD    = 16'h0000;
  localparam bit          LD_HI_FIRST = 1'b1;

endpackage

// File: rtl/prog_mem_server_if.sv
// Loader, controller-fetch and status bundle of the program-memory server.
// slave = server side, master = loader/controller side.
interface prog_mem_server_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = ADDR_W + 1
);

  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              ld_done;
  logic              reload;
  logic              cpu_hold;
  logic              rom_cs;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ProgramCode;
  logic [CNT_W-1:0]  ld_count;
  logic              ld_err;
  logic [15:0]       fetch_count;

  modport slave (
    input  ld_valid, ld_byte, ld_done, reload,
    input  rom_cs, re, addr,
    output ld_ready, cpu_hold, ProgramCode,
    output ld_count, ld_err, fetch_count
  );

  modport master (
    output ld_valid, ld_byte, ld_done, reload,
    output rom_cs, re, addr,
    input  ld_ready, cpu_hold, ProgramCode,
    input  ld_count, ld_err, fetch_count
  );

endinterface

// File: rtl/prog_mem_server_ram.sv
// Program RAM: one synchronous write port, one registered read port.
// The array carries no reset; valid contents are tracked by ld_count.
module prog_ram_2p #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_mem_server.sv
// Boot loader and ROM-fetch responder for the MCU controller.
// Loads 16-bit words from a byte stream, then serves fetches.
module prog_mem_server
  import mcu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = PROG_DEPTH
) (
  input logic clk,
  input logic rst_n,
  prog_mem_server_if.slave bus
);

  localparam int CW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              hit_q, hit_d;
  logic              hold_q;
  logic              re_q;
  logic              accept;
  logic              we;
  logic              rd_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  assign accept = bus.ld_valid & (state_q != RUN);
  assign wdata  = LD_HI_FIRST ? {hi_q, bus.ld_byte}
                              : {bus.ld_byte, hi_q};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    hit_d   = hit_q;
    we      = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      LOAD_HI: begin
        if (accept) begin
          hi_d    = bus.ld_byte;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (accept) begin
          if (cnt_q < CW'(DEPTH)) begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = LOAD_HI;
        end
      end
      RUN: begin
        if (bus.reload) begin
          state_d = LOAD_HI;
          cnt_d   = '0;
          err_d   = 1'b0;
          fcnt_d  = '0;
          hit_d   = 1'b0;
        end else begin
          if (bus.rom_cs) begin
            rd_en = 1'b1;
            hit_d = {1'b0, bus.addr} < cnt_q;
          end
          if (bus.re && !re_q) fcnt_d = fcnt_q + 16'd1;
        end
      end
      default: state_d = LOAD_HI;
    endcase
    // The byte is consumed first; a dangling high byte marks the image bad.
    if (state_q != RUN && bus.ld_done) begin
      if (state_d == LOAD_LO) err_d = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_HI;
      hi_q    <= 8'h00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      hit_q   <= 1'b0;
      hold_q  <= 1'b1;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      hit_q   <= hit_d;
      hold_q  <= (state_d != RUN);
      re_q    <= bus.re;
    end
  end

  prog_ram_2p #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (bus.addr),
    .rdata (rdata)
  );

  assign bus.ld_ready    = (state_q != RUN);
  assign bus.cpu_hold    = hold_q;
  assign bus.ld_count    = cnt_q;
  assign bus.ld_err      = err_q;
  assign bus.fetch_count = fcnt_q;
  assign bus.ProgramCode = hit_q ? rdata : DATA_W'(NOP_WORD);

endmodule
